// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD encoder.
package bin_to_bcd_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int         BCD_W       = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit adjust: a digit of 5..9 gets +3 so the following shift carries correctly.
module bcd_add3_digit
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [BCD_W-1:0] d,
    output logic [BCD_W-1:0] q
);

    assign q = (d >= ADD3_THRESH) ? d + BCD_W'(3) : d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD encoder, one iteration per clock, with leading-zero mask.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold last result
//   CONV  | one double-dabble iteration per clock, cnt counts down to 1
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin,
    output logic                      busy,
    output logic                      done,
    output logic [BCD_W*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]         blank,
    output logic                      overflow
);

    localparam int                SCR_W     = BCD_W * DIGITS;
    localparam int                CNT_W     = $clog2(BIN_W + 1);
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   shreg_q, shreg_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic               ovf_q, ovf_d;
    logic               busy_d, done_d, overflow_d;
    logic [SCR_W-1:0]   bcd_d;
    logic [DIGITS-1:0]  blank_d;

    logic [SCR_W-1:0]   adj;
    logic [SCR_W-1:0]   scratch_sh;
    logic               shift_out;
    logic [DIGITS-1:0]  blank_calc;
    logic               hi_zero;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3_digit u_add3 (
            .d (scratch_q[g*BCD_W +: BCD_W]),
            .q (adj[g*BCD_W +: BCD_W])
        );
    end

    assign shift_out  = adj[SCR_W-1];
    assign scratch_sh = {adj[SCR_W-2:0], shreg_q[BIN_W-1]};

    // A digit blanks only when it and every digit above it are zero; units never blanks.
    always_comb begin
        blank_calc = '0;
        hi_zero    = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            hi_zero       = hi_zero & (scratch_sh[i*BCD_W +: BCD_W] == '0);
            blank_calc[i] = hi_zero;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        ovf_d      = ovf_q;
        busy_d     = busy;
        done_d     = 1'b0;
        bcd_d      = bcd;
        blank_d    = blank;
        overflow_d = overflow;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d   = bin;
                    scratch_d = '0;
                    ovf_d     = 1'b0;
                    cnt_d     = CNT_W'(BIN_W);
                    busy_d    = 1'b1;
                    state_d   = CONV;
                end
            end
            CONV: begin
                scratch_d = scratch_sh;
                shreg_d   = {shreg_q[BIN_W-2:0], 1'b0};
                ovf_d     = ovf_q | shift_out;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d      = scratch_sh;
                    overflow_d = ovf_q | shift_out;
                    blank_d    = blank_calc;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            scratch_q <= '0;
            ovf_q     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd       <= '0;
            blank     <= BLANK_RST;
            overflow  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            ovf_q     <= ovf_d;
            busy      <= busy_d;
            done      <= done_d;
            bcd       <= bcd_d;
            blank     <= blank_d;
            overflow  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq: a 3-digit instance plus a 2-digit overflow instance.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start2;
    logic [7:0]  bin, bin2;
    logic        busy, done, overflow;
    logic [11:0] bcd;
    logic [2:0]  blank;
    logic        busy2, done2, overflow2;
    logic [7:0]  bcd2;
    logic [1:0]  blank2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .blank(blank), .overflow(overflow)
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2), .blank(blank2), .overflow(overflow2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        ref_bcd = 12'((v / 100) << 8 | ((v / 10) % 10) << 4 | (v % 10));
    endfunction

    function automatic logic [2:0] ref_blank(input int v);
        if (v < 10)       ref_blank = 3'b110;
        else if (v < 100) ref_blank = 3'b100;
        else              ref_blank = 3'b000;
    endfunction

    // Called on a negedge; returns at the negedge where done is seen (or after a bound).
    task automatic run(input logic [7:0] v, output int lat, output int busy_cnt);
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        start = 1'b0;
        bin   = ~v;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run2(input logic [7:0] v, output int lat);
        start2 = 1'b1;
        bin2   = v;
        @(negedge clk);
        start2 = 1'b0;
        bin2   = ~v;
        lat = 0;
        while (!done2 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int   lat, bcnt, pulses;
        time  t_prev, t_now;

        rst = 1'b1; start = 1'b0; bin = '0; start2 = 1'b0; bin2 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd), 32'h000);
        check("rst_blank", 32'(blank), 32'b110);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run(8'd0, lat, bcnt);
        check("zero_lat", 32'(lat), 32'd8);
        check("zero_busy_cycles", 32'(bcnt), 32'd8);
        check("zero_busy_at_done", 32'(busy), 32'd0);
        check("zero_bcd", 32'(bcd), 32'h000);
        check("zero_blank", 32'(blank), 32'b110);
        check("zero_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);

        run(8'd255, lat, bcnt);
        check("d255_bcd", 32'(bcd), 32'h255);
        check("d255_blank", 32'(blank), 32'b000);
        check("d255_ovf", 32'(overflow), 32'd0);
        run(8'd9, lat, bcnt);
        check("d9_bcd", 32'(bcd), 32'h009);
        check("d9_blank", 32'(blank), 32'b110);
        run(8'd42, lat, bcnt);
        check("d42_bcd", 32'(bcd), 32'h042);
        check("d42_blank", 32'(blank), 32'b100);

        // Exhaustive sweep, each conversion restarted in the done cycle.
        t_prev = $time;
        for (int v = 0; v < 256; v++) begin
            t_now = $time;
            run(8'(v), lat, bcnt);
            if (v > 0) check($sformatf("sweep_spacing_%0d", v), 32'(t_now - t_prev), 32'd90);
            t_prev = t_now;
            check($sformatf("sweep_lat_%0d", v), 32'(lat), 32'd8);
            check($sformatf("sweep_bcd_%0d", v), 32'(bcd), 32'(ref_bcd(v)));
            check($sformatf("sweep_blank_%0d", v), 32'(blank), 32'(ref_blank(v)));
            check($sformatf("sweep_ovf_%0d", v), 32'(overflow), 32'd0);
        end
        @(negedge clk);

        // start while busy must be ignored
        start = 1'b1; bin = 8'd100;
        @(negedge clk);
        start = 1'b0; bin = 8'd7;
        repeat (2) @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                check("ign_bcd", 32'(bcd), 32'h100);
                check("ign_blank", 32'(blank), 32'b000);
            end
        end
        check("ign_pulses", 32'(pulses), 32'd1);
        check("ign_busy_end", 32'(busy), 32'd0);

        // reset on the 4th CONV edge aborts the conversion
        start = 1'b1; bin = 8'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_pulses", 32'(pulses), 32'd0);
        check("abort_bcd", 32'(bcd), 32'h000);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_blank", 32'(blank), 32'b110);
        check("abort_ovf", 32'(overflow), 32'd0);
        run(8'd37, lat, bcnt);
        check("after_abort_lat", 32'(lat), 32'd8);
        check("after_abort_bcd", 32'(bcd), 32'h037);
        check("after_abort_blank", 32'(blank), 32'b100);
        @(negedge clk);

        // two-digit instance: overflow and modulo behaviour
        run2(8'd123, lat);
        check("d2_123_lat", 32'(lat), 32'd8);
        check("d2_123_bcd", 32'(bcd2), 32'h23);
        check("d2_123_ovf", 32'(overflow2), 32'd1);
        check("d2_123_blank", 32'(blank2), 32'b00);
        run2(8'd99, lat);
        check("d2_99_bcd", 32'(bcd2), 32'h99);
        check("d2_99_ovf", 32'(overflow2), 32'd0);
        run2(8'd5, lat);
        check("d2_5_bcd", 32'(bcd2), 32'h05);
        check("d2_5_blank", 32'(blank2), 32'b10);
        run2(8'd200, lat);
        check("d2_200_bcd", 32'(bcd2), 32'h00);
        check("d2_200_ovf", 32'(overflow2), 32'd1);
        check("d2_200_blank", 32'(blank2), 32'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD encoder using shift-and-add-3 (double dabble), one iteration per clock. It produces packed BCD digits plus a leading-zero blanking mask. Its outputs drive the per-digit BCD-to-seven-segment decoders in the display path, so it is the producing end of the BCD digit interface. The interface is a start/busy/done handshake, so counters and datapaths hand it a value and collect the result.

Parameters:
BIN_W, 8, width of the binary input; also the iteration count.
DIGITS, 3, number of BCD digits produced; bcd width is 4*DIGITS.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request a conversion of bin; sampled only in IDLE.
bin  input  BIN_W  unsigned binary value; sampled on the accepting edge only.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse when bcd/blank/overflow update.
bcd  output  4*DIGITS  packed result; digit 0 (units) in bits [3:0].
blank  output  DIGITS  bit i high = digit i is a leading zero (bit 0 is always 0).
overflow  output  1  value exceeded 10^DIGITS-1; bcd then holds value mod 10^DIGITS.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0; done=0; overflow=0; bcd=0; blank={DIGITS-1{1'b1},1'b0}; scratch, shift register and counter are cleared.
- Reset has priority over everything. Reset mid-conversion aborts: no done pulse, and outputs return to reset values.
- States: IDLE, CONV.
- IDLE with start=1 at edge E0:
  - shift reg <= bin; scratch <= 0; ovf_acc <= 0; cnt <= BIN_W; busy <= 1; go to CONV.
- IDLE with start=0: hold; done is driven 0 after any pulse.
- CONV, each edge:
  - Every scratch digit >= 5 gets +3 (4-bit, no carry out of the digit).
  - Then {scratch, shift reg} shifts left by 1.
  - The bit shifted out of the top digit is ORed into ovf_acc.
  - cnt decrements.
- Last iteration (cnt==1), same edge:
  - bcd <= final scratch; overflow <= ovf_acc | shifted-out bit; blank computed from the final digits; done <= 1; busy <= 0; go to IDLE.
- Latency: done is high in the cycle following edge E0+BIN_W (BIN_W=8: 8 clocks after the accepting edge).
- Throughput: one conversion per BIN_W+1 cycles. start is accepted in the cycle where done=1, so the earliest back-to-back accept is edge E0+BIN_W+1.
- start while busy is ignored, and bin is not resampled.
- bcd, blank and overflow hold their last values until the next done; they are never partially updated.
- blank[i] (i>0) = digit i and all higher digits are zero. blank[0] = 0, so the value 0 shows a single "0".
- Digits are always valid BCD (0-9) after done. The add-3 is applied before the shift, never after the final shift.
- A single driver per output; no combinational path from inputs to outputs.

Decomposition:
- Shared package: state encoding (IDLE, CONV), the BCD digit width constant (4), and the add-3 threshold constant (5).
- One sub-module, bcd_add3_digit: 4-bit combinational digit adjust, returning d+3 if d>=5, else d. It is instantiated DIGITS times via generate.
- Counter width is clog2(BIN_W+1).

Test Plan:
- rst, then start with bin=8'd0 -> done after 8 clocks; bcd=12'h000; blank=3'b110; overflow=0; busy high for exactly 8 cycles.
- bin=8'd255 -> bcd=12'h255, blank=3'b000, overflow=0. bin=8'd9 -> bcd=12'h009, blank=3'b110. bin=8'd42 -> bcd=12'h042, blank=3'b100.
- Exhaustive sweep bin=0..255, each restarted in the done cycle -> bcd matches the decimal reference every time; accept spacing is exactly 9 cycles.
- start with bin=8'd100, then start=1 with bin=8'd7 during CONV -> result 12'h100; the second request is ignored; only one done pulse.
- start with bin=8'd200, assert rst at the 4th CONV cycle -> no done; bcd=0; busy=0. A following start with bin=8'd37 -> 12'h037.
- DIGITS=2, bin=8'd123 -> bcd=8'h23, overflow=1. bin=8'd99 -> bcd=8'h99, overflow=0.
